// File: rtl/qr_pkg.sv
// qr_pkg: shared types, widths and saturation helper for the adaptive threshold controller.
//   LUMA_W      width of a luma sample
//   THRESH_W    width of the binarizer threshold bus
//   thr_state_t controller FSM states
//   sat_luma    clamps a signed blend result into the 0..255 luma range
package qr_pkg;

    localparam int LUMA_W   = 8;
    localparam int THRESH_W = 9;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, BLEND} thr_state_t;

    function automatic logic [LUMA_W-1:0] sat_luma(input logic signed [LUMA_W+2:0] v);
        return (v < 11'sd0) ? '0 : ((v > 11'sd255) ? '1 : v[LUMA_W-1:0]);
    endfunction

endpackage

// File: rtl/luma_stats.sv
// luma_stats: running per-frame min/max of the luma stream.
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   clear_in          restart the statistics this cycle
//   valid_in          luma_in is a pixel to fold in
//   luma_in           pixel luma
//   min_out, max_out  running minimum / maximum
//   seen_out          at least one pixel folded in since the last clear
module luma_stats
    import qr_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              clear_in,
    input  logic              valid_in,
    input  logic [LUMA_W-1:0] luma_in,
    output logic [LUMA_W-1:0] min_out,
    output logic [LUMA_W-1:0] max_out,
    output logic              seen_out
);

    logic [LUMA_W-1:0] base_min;
    logic [LUMA_W-1:0] base_max;
    logic              base_seen;

    // A clear coinciding with a pixel starts the new frame with that pixel,
    // since frame_start arrives together with the first pixel.
    always_comb begin
        base_min  = clear_in ? '1 : min_out;
        base_max  = clear_in ? '0 : max_out;
        base_seen = clear_in ? 1'b0 : seen_out;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            min_out  <= '1;
            max_out  <= '0;
            seen_out <= 1'b0;
        end else begin
            min_out  <= (valid_in && luma_in < base_min) ? luma_in : base_min;
            max_out  <= (valid_in && luma_in > base_max) ? luma_in : base_max;
            seen_out <= base_seen | valid_in;
        end
    end

endmodule

// File: rtl/threshold_ctrl.sv
// threshold_ctrl: per-frame adaptive threshold for the pixel binarizer.
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   frame_start_in     pulse with the first pixel of a frame
//   frame_end_in       pulse after the last pixel of a frame
//   pixel_valid_in     luma_in carries a pixel
//   luma_in            pixel luma
//   manual_en_in       select manual_thresh_in instead of the computed threshold
//   manual_thresh_in   manual threshold, saturated to 255
//   thresh_out         registered threshold to the binarizer (0..255)
//   thresh_update_out  pulse when thresh_out changes
//   busy_out           high while accumulating, computing or blending
module threshold_ctrl
    import qr_pkg::*;
#(
    parameter logic [THRESH_W-1:0] DEFAULT_THRESH = 9'd128,
    parameter int                  SMOOTH_SHIFT   = 2,
    parameter logic [LUMA_W-1:0]   MIN_CONTRAST   = 8'd32
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                frame_start_in,
    input  logic                frame_end_in,
    input  logic                pixel_valid_in,
    input  logic [LUMA_W-1:0]   luma_in,
    input  logic                manual_en_in,
    input  logic [THRESH_W-1:0] manual_thresh_in,
    output logic [THRESH_W-1:0] thresh_out,
    output logic                thresh_update_out,
    output logic                busy_out
);

    thr_state_t state, state_next;
    logic              pending_start, pending_next;
    logic              stats_clear, stats_en;
    logic [LUMA_W-1:0] stat_min, stat_max;
    logic              stat_seen;
    logic [LUMA_W-1:0] target;
    logic              reject;
    logic [LUMA_W-1:0] thresh_auto;
    logic [LUMA_W:0]   sum_mm;
    logic [LUMA_W-1:0] contrast;
    logic signed [LUMA_W+1:0] diff, step;
    logic signed [LUMA_W+2:0] blended;
    logic [LUMA_W-1:0] manual_sat;
    logic [THRESH_W-1:0] thresh_next;

    luma_stats u_stats (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear_in (stats_clear),
        .valid_in (pixel_valid_in & stats_en),
        .luma_in  (luma_in),
        .min_out  (stat_min),
        .max_out  (stat_max),
        .seen_out (stat_seen)
    );

    // Statistics are only read during COMPUTE, so a frame_start seen in
    // COMPUTE/BLEND can restart them immediately and the early pixels of the
    // next frame are kept rather than dropped.
    always_comb begin
        state_next   = state;
        pending_next = pending_start;
        stats_clear  = frame_start_in;
        stats_en     = frame_start_in | pending_start;
        case (state)
            IDLE: begin
                if (frame_start_in || pending_start) begin
                    state_next   = ACCUM;
                    pending_next = 1'b0;
                end
            end
            ACCUM: begin
                stats_en = 1'b1;
                if (frame_end_in && !frame_start_in) state_next = COMPUTE;
            end
            COMPUTE: begin
                state_next   = BLEND;
                pending_next = pending_start | frame_start_in;
            end
            default: begin
                state_next   = (pending_start || frame_start_in) ? ACCUM : IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        sum_mm      = {1'b0, stat_min} + {1'b0, stat_max};
        contrast    = stat_max - stat_min;
        diff        = $signed({2'b00, target}) - $signed({2'b00, thresh_auto});
        step        = diff >>> SMOOTH_SHIFT;
        blended     = $signed({3'b000, thresh_auto}) + $signed({step[LUMA_W+1], step});
        manual_sat  = (manual_thresh_in > 9'd255) ? 8'hFF : manual_thresh_in[LUMA_W-1:0];
        thresh_next = {1'b0, manual_en_in ? manual_sat : thresh_auto};
        busy_out    = (state != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            pending_start     <= 1'b0;
            target            <= '0;
            reject            <= 1'b1;
            thresh_auto       <= DEFAULT_THRESH[LUMA_W-1:0];
            thresh_out        <= DEFAULT_THRESH;
            thresh_update_out <= 1'b0;
        end else begin
            state             <= state_next;
            pending_start     <= pending_next;
            thresh_out        <= thresh_next;
            thresh_update_out <= (thresh_next != thresh_out);
            if (state == COMPUTE) begin
                target <= sum_mm[LUMA_W:1];
                reject <= !stat_seen || (contrast < MIN_CONTRAST);
            end
            if (state == BLEND && !reject) thresh_auto <= sat_luma(blended);
        end
    end

endmodule

// File: tb/tb_threshold_ctrl.sv
// tb_threshold_ctrl: directed bench driving an unsmoothed and a smoothed controller in parallel.
module tb_threshold_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       fs = 1'b0, fe = 1'b0, pv = 1'b0, men = 1'b0;
    logic [7:0] luma = '0;
    logic [8:0] mthr = '0;
    logic [8:0] thr0, thr2;
    logic       upd0, upd2, busy0, busy2;
    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    threshold_ctrl #(.SMOOTH_SHIFT(0)) dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(fs), .frame_end_in(fe),
        .pixel_valid_in(pv), .luma_in(luma), .manual_en_in(men), .manual_thresh_in(mthr),
        .thresh_out(thr0), .thresh_update_out(upd0), .busy_out(busy0)
    );

    threshold_ctrl #(.SMOOTH_SHIFT(2)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(fs), .frame_end_in(fe),
        .pixel_valid_in(pv), .luma_in(luma), .manual_en_in(men), .manual_thresh_in(mthr),
        .thresh_out(thr2), .thresh_update_out(upd2), .busy_out(busy2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        fs = 1'b1; pv = 1'b1; luma = a; step();
        chk("busy_accum0", busy0, 1);
        chk("busy_accum2", busy2, 1);
        fs = 1'b0; luma = b; step();
        luma = c; step();
        pv = 1'b0; fe = 1'b1; step();
        fe = 1'b0;
    endtask

    task automatic finish_frame(input int e0, input int u0, input int e2, input int u2,
                                input int p0, input int p2);
        chk("busy_compute0", busy0, 1);
        chk("busy_compute2", busy2, 1);
        step();
        chk("busy_blend0", busy0, 1);
        chk("busy_blend2", busy2, 1);
        step();
        chk("busy_idle0", busy0, 0);
        chk("busy_idle2", busy2, 0);
        chk("thr_hold0", thr0, p0);
        chk("thr_hold2", thr2, p2);
        step();
        chk("thr0", thr0, e0);
        chk("upd0", upd0, u0);
        chk("thr2", thr2, e2);
        chk("upd2", upd2, u2);
        step();
        chk("upd_drop0", upd0, 0);
        chk("upd_drop2", upd2, 0);
    endtask

    initial begin
        step(); step();
        rst_n_in = 1'b1;
        step(); step(); step();
        chk("rst_thr0", thr0, 128);
        chk("rst_thr2", thr2, 128);
        chk("rst_upd0", upd0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_busy2", busy2, 0);

        // target (20+220)/2 = 120; smoothed: 128 + (-8>>>2) = 126
        send3(8'd20, 8'd220, 8'd150);
        finish_frame(120, 1, 126, 1, 128, 128);

        // asynchronous reset in the middle of a frame
        fs = 1'b1; pv = 1'b1; luma = 8'd90; step();
        fs = 1'b0; luma = 8'd10; step();
        #2 rst_n_in = 1'b0;
        #1;
        chk("mid_rst_thr0", thr0, 128);
        chk("mid_rst_thr2", thr2, 128);
        chk("mid_rst_busy0", busy0, 0);
        chk("mid_rst_upd0", upd0, 0);
        pv = 1'b0;
        step(); step();
        rst_n_in = 1'b1;
        step();
        chk("post_rst_busy0", busy0, 0);

        // target 200: 128 -> 146 -> 159 smoothed; unsmoothed repeats give no pulse
        send3(8'd150, 8'd200, 8'd250);
        finish_frame(200, 1, 146, 1, 128, 128);
        send3(8'd150, 8'd200, 8'd250);
        finish_frame(200, 0, 159, 1, 200, 146);

        // flat frame and empty frame are rejected
        send3(8'd100, 8'd100, 8'd100);
        finish_frame(200, 0, 159, 0, 200, 159);
        fs = 1'b1; step();
        fs = 1'b0; fe = 1'b1; step();
        fe = 1'b0;
        finish_frame(200, 0, 159, 0, 200, 159);

        // contrast 31 rejected, 32 accepted (target 116; 159 + (-43>>>2) = 148)
        send3(8'd100, 8'd131, 8'd120);
        finish_frame(200, 0, 159, 0, 200, 159);
        send3(8'd100, 8'd132, 8'd120);
        finish_frame(116, 1, 148, 1, 200, 159);

        // back-to-back frames: target 127 (148 -> 142), then 40..160 -> 100 (142 -> 131)
        send3(8'd0, 8'd255, 8'd128);
        chk("bb_busy_c", busy0, 1);
        fs = 1'b1; pv = 1'b1; luma = 8'd100; step();
        chk("bb_busy_b", busy0, 1);
        fs = 1'b0; step();
        chk("bb_busy_a0", busy0, 1);
        chk("bb_busy_a2", busy2, 1);
        step();
        chk("bb_thr0", thr0, 127);
        chk("bb_upd0", upd0, 1);
        chk("bb_thr2", thr2, 142);
        chk("bb_upd2", upd2, 1);
        luma = 8'd40; step();
        luma = 8'd160; step();
        pv = 1'b0; fe = 1'b1; step();
        fe = 1'b0;
        finish_frame(100, 1, 131, 1, 127, 142);

        // manual override saturates to 255
        men = 1'b1; mthr = 9'd300; step();
        chk("man_thr0", thr0, 255);
        chk("man_upd0", upd0, 1);
        chk("man_thr2", thr2, 255);
        step();
        chk("man_upd_drop", upd0, 0);
        mthr = 9'd50; step();
        chk("man50_thr0", thr0, 50);
        chk("man50_upd2", upd2, 1);

        // auto path keeps learning under manual: 100 -> 200, 131 -> 148
        send3(8'd150, 8'd200, 8'd250);
        finish_frame(50, 0, 50, 0, 50, 50);
        men = 1'b0; step();
        chk("auto_back_thr0", thr0, 200);
        chk("auto_back_upd0", upd0, 1);
        chk("auto_back_thr2", thr2, 148);
        chk("auto_back_upd2", upd2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
